echo_tx_ctrl: RTL and testbench
===============================

// Module: echo_tx_ctrl
// PURPOSE
//  Sequences the TCP transmit path for the echo kernel. Takes each packet from pkt_receiver's
//  pkt_tx stream ({meta[87:0], tlast, data[511:0]}, meta sent on every beat) and requests tx with
//  {length, session}. It waits for tx_status, then forwards the payload beats to the stack.
//  A refused send is retried with backoff; after MAX_RETRY retries the packet is drained (dropped).
// PARAMETERS
//  MAX_RETRY       3     retries after first refusal before drop (4b counter, 0..15)
//  BACKOFF_CYCLES  64    idle cycles between refusal and re-request (16b counter)
//  TIMEOUT_CYCLES  1024  STATUS wait limit; expiry counts as refusal (16b counter)
// PORTS
//  clk                      in   1    kernel clock
//  rst                      in   1    synchronous, active-high reset
//  s_axis_pkt_TDATA         in   601  [600:513] meta (sess[15:0], len[31:16]), [512] tlast, [511:0] data
//  s_axis_pkt_TVALID        in   1    packet beat valid
//  s_axis_pkt_TREADY        out  1    packet beat accept
//  m_axis_tx_meta_TDATA     out  32   {len[31:16], sess[15:0]}
//  m_axis_tx_meta_TVALID    out  1    tx request valid
//  m_axis_tx_meta_TREADY    in   1    tx request accept
//  s_axis_tx_status_TDATA   in   64   [15:0] sess, [31:16] len, [61:32] space, [63:62] error
//  s_axis_tx_status_TVALID  in   1    status valid
//  s_axis_tx_status_TREADY  out  1    status accept
//  m_axis_tx_data_TDATA     out  513  {tlast, data[511:0]}; all beats full, no keep
//  m_axis_tx_data_TVALID    out  1    tx payload valid
//  m_axis_tx_data_TREADY    in   1    tx payload accept
// BEHAVIOUR
//  - Reset: state=IDLE, all TVALID/TREADY outs 0, meta TDATA 0, retry/backoff/timeout counters 0.
//  - IDLE: s_axis_pkt_TREADY=0 (peek only). On pkt TVALID, latch sess/len from TDATA[600:513].
//    len==0 -> DROP, else META. Meta TVALID rises 1 cycle after pkt TVALID is first seen.
//  - META: meta TVALID=1, TDATA={len,sess}, both held stable until TREADY. Handshake -> STATUS.
//  - STATUS: status TREADY=1; timeout counter increments from 0 each cycle.
//    Accept on TVALID: error==0 and sess match -> DATA.
//    Error!=0, sess mismatch, or timeout==TIMEOUT_CYCLES-1 without status -> refusal.
//  - Refusal: retry<MAX_RETRY -> retry++, BACKOFF; else -> DROP.
//  - BACKOFF: count BACKOFF_CYCLES cycles, then META with the latched sess/len.
//  - DATA: m_axis_tx_data_TVALID = s_axis_pkt_TVALID and TDATA = s_axis_pkt_TDATA[512:0].
//    s_axis_pkt_TREADY = m_axis_tx_data_TREADY (combinational, zero latency, no bubbles).
//    Beat with tlast handshaken -> IDLE; retry counter cleared.
//  - DROP: s_axis_pkt_TREADY=1, tx_data TVALID=0. Beat with tlast consumed -> IDLE, retry cleared.
//  - s_axis_tx_status_TREADY=0 in every state except STATUS; stray statuses stay upstream.
//  - Exactly one packet in flight; len is not checked against beat count (tlast governs).
//  - Reset mid-packet: IDLE next cycle, all valids/readies low; partially sent packet abandoned.
//  - Back-to-back packets: IDLE entered after tlast; next meta TVALID 1 cycle later at earliest.
// CONFIGURATION
//  ECHO_TX_CTRL_STATS_EN defined: adds outputs stat_sent[31:0], stat_dropped[31:0] and
//    stat_retries[31:0]. Counters reset to 0, wrap at 2^32, update 1 cycle after the event:
//    stat_sent on the tlast handshake in DATA, stat_dropped on tlast consumed in DROP,
//    stat_retries on each refusal that leads to BACKOFF.
//  ECHO_TX_CTRL_STATS_EN undefined: these ports and counters are absent; behaviour otherwise identical.
// TESTING
//  1. sess=0x0005, len=128 (2 beats), status err=0 -> meta 0x00800005, 2 beats out, tlast on beat 2.
//  2. Status err=1 twice, then err=0 -> 3 meta requests, each re-request >=64 cycles after refusal;
//     data forwarded once.
//  3. Status err=2 four times (MAX_RETRY=3) -> 4 meta requests, no tx_data TVALID, 2 beats drained.
//     With stats: dropped=1, retries=3.
//  4. No status for 1024 cycles -> treated as refusal; status arriving during BACKOFF stays
//     pending (TREADY=0) and is accepted in the next STATUS.
//  5. DATA with m_axis_tx_data_TREADY toggling 1010 -> s_axis_pkt_TREADY mirrors it;
//     no beat lost or duplicated.
//  6. rst pulsed during DATA beat 1 of 3 -> all valids/readies 0 next cycle; state IDLE; counters 0.

Source files
------------

// File: rtl/echo_tx_ctrl_if.sv
// Purpose : valid/ready stream bundle (data, valid, ready) used by every
//           echo_tx_ctrl port, with master and slave views.
// Ports   : tdata[W-1:0], tvalid (master -> slave), tready (slave -> master).
// Latency : none, wires only. Backpressure: tready from the slave side.
interface echo_tx_ctrl_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/echo_tx_ctrl.sv
// Purpose : sequences one echo packet at a time onto the TCP tx path. It sends a
//           {len,sess} tx request and waits for tx_status. On success it forwards
//           the payload. A refusal or timeout is retried after a backoff; once the
//           retries are used up, the packet is drained.
// Latency : meta valid 1 cycle after a packet is seen; payload is a zero-latency
//           pass-through (no bubbles).
// Backpressure: payload ready mirrors m_axis_tx_data ready. Stray statuses are held
//           upstream (ready low outside STATUS).
// Ports   : clk, rst (sync, active high); s_axis_pkt (601b beats, slave);
//           m_axis_tx_meta (32b request, master); s_axis_tx_status (64b, slave);
//           m_axis_tx_data (513b {tlast,data}, master).
//           Optional stat_sent/stat_dropped/stat_retries[31:0] are present only when
//           the macro ECHO_TX_CTRL_STATS_EN is defined.
module echo_tx_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  echo_tx_ctrl_if.slave  s_axis_pkt,
  echo_tx_ctrl_if.master m_axis_tx_meta,
  echo_tx_ctrl_if.slave  s_axis_tx_status,
  echo_tx_ctrl_if.master m_axis_tx_data
`ifdef ECHO_TX_CTRL_STATS_EN
  ,
  output logic [31:0]    stat_sent,
  output logic [31:0]    stat_dropped,
  output logic [31:0]    stat_retries
`endif
);

  typedef enum logic [2:0] {IDLE, META, STATUS, BACKOFF, DATA, DROP} state_e;

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] BO_LAST   = 16'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] sess_q, sess_d;
  logic [15:0] len_q, len_d;
  logic [3:0]  retry_q, retry_d;
  // Shared by the STATUS timeout and the BACKOFF wait; they are never active together.
  logic [15:0] cnt_q, cnt_d;
  logic        refuse;

  logic [15:0] pkt_sess, pkt_len, st_sess;
  logic        pkt_last;
  logic [1:0]  st_err;
  logic        unused_bits;

  assign pkt_sess    = s_axis_pkt.tdata[528:513];
  assign pkt_len     = s_axis_pkt.tdata[544:529];
  assign pkt_last    = s_axis_pkt.tdata[512];
  assign st_sess     = s_axis_tx_status.tdata[15:0];
  assign st_err      = s_axis_tx_status.tdata[63:62];
  assign unused_bits = ^{s_axis_pkt.tdata[600:545], s_axis_tx_status.tdata[61:16]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sess_q  <= '0;
      len_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sess_q  <= sess_d;
      len_q   <= len_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sess_d  = sess_q;
    len_d   = len_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    refuse  = 1'b0;
    case (state_q)
      IDLE: begin
        // Peek at the first beat only; it stays upstream until DATA or DROP.
        if (s_axis_pkt.tvalid) begin
          sess_d  = pkt_sess;
          len_d   = pkt_len;
          state_d = (pkt_len == 16'd0) ? DROP : META;
        end
      end
      META: begin
        if (m_axis_tx_meta.tready) begin
          cnt_d   = '0;
          state_d = STATUS;
        end
      end
      STATUS: begin
        // A status arriving on the last timeout cycle still wins over the timeout.
        if (s_axis_tx_status.tvalid) begin
          if (st_err == 2'd0 && st_sess == sess_q) state_d = DATA;
          else                                     refuse  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          refuse = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (refuse) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            cnt_d   = '0;
            state_d = BACKOFF;
          end else begin
            state_d = DROP;
          end
        end
      end
      BACKOFF: begin
        if (cnt_q == BO_LAST) state_d = META;
        else                  cnt_d   = cnt_q + 16'd1;
      end
      DATA: begin
        if (s_axis_pkt.tvalid && m_axis_tx_data.tready && pkt_last) begin
          retry_d = '0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (s_axis_pkt.tvalid && pkt_last) begin
          retry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  assign m_axis_tx_meta.tdata = {len_q, sess_q};

  always_comb begin
    s_axis_pkt.tready       = 1'b0;
    m_axis_tx_meta.tvalid   = 1'b0;
    s_axis_tx_status.tready = 1'b0;
    m_axis_tx_data.tvalid   = 1'b0;
    m_axis_tx_data.tdata    = s_axis_pkt.tdata[512:0];
    case (state_q)
      META:   m_axis_tx_meta.tvalid   = 1'b1;
      STATUS: s_axis_tx_status.tready = 1'b1;
      DATA: begin
        m_axis_tx_data.tvalid = s_axis_pkt.tvalid;
        s_axis_pkt.tready     = m_axis_tx_data.tready;
      end
      DROP:   s_axis_pkt.tready = 1'b1;
      default: ;
    endcase
  end

`ifdef ECHO_TX_CTRL_STATS_EN
  logic        sent_ev, drop_ev, retry_ev;
  logic [31:0] stat_sent_q, stat_sent_d;
  logic [31:0] stat_dropped_q, stat_dropped_d;
  logic [31:0] stat_retries_q, stat_retries_d;

  assign sent_ev  = (state_q == DATA) && s_axis_pkt.tvalid && m_axis_tx_data.tready && pkt_last;
  assign drop_ev  = (state_q == DROP) && s_axis_pkt.tvalid && pkt_last;
  assign retry_ev = refuse && (retry_q < RETRY_MAX);

  always_comb begin
    stat_sent_d    = stat_sent_q    + 32'(sent_ev);
    stat_dropped_d = stat_dropped_q + 32'(drop_ev);
    stat_retries_d = stat_retries_q + 32'(retry_ev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sent_q    <= '0;
      stat_dropped_q <= '0;
      stat_retries_q <= '0;
    end else begin
      stat_sent_q    <= stat_sent_d;
      stat_dropped_q <= stat_dropped_d;
      stat_retries_q <= stat_retries_d;
    end
  end

  assign stat_sent    = stat_sent_q;
  assign stat_dropped = stat_dropped_q;
  assign stat_retries = stat_retries_q;
`endif

endmodule

// File: tb/tb_echo_tx_ctrl.sv
// Purpose : directed bench for echo_tx_ctrl. It uses a stream-level scoreboard and
//           protocol model that check every cycle, plus literal per-test expectations.
// Latency : n/a. Backpressure: the bench drives meta/data ready and status valid.
// Ports   : none (top of simulation).
module tb_echo_tx_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  echo_tx_ctrl_if #(.W(601)) pkt_if ();
  echo_tx_ctrl_if #(.W(32))  meta_if ();
  echo_tx_ctrl_if #(.W(64))  st_if ();
  echo_tx_ctrl_if #(.W(513)) dat_if ();

`ifdef ECHO_TX_CTRL_STATS_EN
  logic [31:0] stat_sent, stat_dropped, stat_retries;
`endif

  echo_tx_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_pkt       (pkt_if),
    .m_axis_tx_meta   (meta_if),
    .s_axis_tx_status (st_if),
    .m_axis_tx_data   (dat_if)
`ifdef ECHO_TX_CTRL_STATS_EN
    ,
    .stat_sent        (stat_sent),
    .stat_dropped     (stat_dropped),
    .stat_retries     (stat_retries)
`endif
  );

  localparam int TIMEOUT = 1024;
  localparam int BACKOFF = 64;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [512:0] act, input logic [512:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model / scoreboard state ----------------
  logic [512:0] exp_data[$];
  logic [31:0]  exp_meta = '0;
  logic [31:0]  last_meta_hs = '0;
  longint cyc = 0;
  longint last_st_rdy_cyc = -1000, last_pkt_end_cyc = -1000;
  longint pkt_rise_cyc = 0, meta_rise_cyc = 0;
  int     n_meta_hs = 0, n_data_hs = 0, n_pkt_hs = 0, n_st_hs = 0;
  bit     awaiting = 0;
  int     await_cnt = 0;
  logic   prev_mvld = 0, prev_mrdy = 0, prev_pvld = 0;
  logic [31:0] prev_mdat = '0;

  // One compare process: protocol rules and payload scoreboard, every cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      awaiting  = 0;
      await_cnt = 0;
      prev_mvld = 0;
      prev_pvld = 0;
    end else begin
      if (meta_if.tvalid) chk("meta_dat", meta_if.tdata, exp_meta);
      if (prev_mvld && !prev_mrdy) begin
        chk("meta_hold_vld", meta_if.tvalid, 1);
        chk("meta_hold_dat", meta_if.tdata, prev_mdat);
      end
      if (meta_if.tvalid && !prev_mvld) begin
        meta_rise_cyc = cyc;
        // A re-request must follow the refusal by at least the full backoff.
        if (last_st_rdy_cyc > last_pkt_end_cyc)
          chk("backoff_gap", longint'((cyc - last_st_rdy_cyc) >= BACKOFF + 1), 1);
      end
      if (pkt_if.tvalid && !prev_pvld) pkt_rise_cyc = cyc;

      // Status is taken only while a request is outstanding, and for at most TIMEOUT cycles.
      chk("status_tready", st_if.tready, awaiting);
      if (st_if.tready) begin
        last_st_rdy_cyc = cyc;
        await_cnt++;
        if (st_if.tvalid) begin
          n_st_hs++;
          awaiting  = 0;
          await_cnt = 0;
        end else if (await_cnt == TIMEOUT) begin
          awaiting  = 0;
          await_cnt = 0;
        end
      end

      if (dat_if.tvalid) begin
        chk("pkt_rdy_mirror", pkt_if.tready, dat_if.tready);
        chk("data_needs_pkt_vld", pkt_if.tvalid, 1);
        chk_w("data_passthru", dat_if.tdata, pkt_if.tdata[512:0]);
      end
      if (dat_if.tvalid && dat_if.tready) begin
        n_data_hs++;
        if (exp_data.size() == 0) chk("data_unexpected", 1, 0);
        else chk_w("data_beat", dat_if.tdata, exp_data.pop_front());
      end
      if (pkt_if.tvalid && pkt_if.tready) begin
        n_pkt_hs++;
        if (pkt_if.tdata[512]) last_pkt_end_cyc = cyc;
      end
      if (meta_if.tvalid && meta_if.tready) begin
        n_meta_hs++;
        last_meta_hs = meta_if.tdata;
        awaiting  = 1;
        await_cnt = 0;
      end
      prev_mvld = meta_if.tvalid;
      prev_mrdy = meta_if.tready;
      prev_mdat = meta_if.tdata;
      prev_pvld = pkt_if.tvalid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [600:0] mk_beat(input logic [15:0] sess, input logic [15:0] len,
                                           input int b, input bit last);
    logic [31:0] w;
    w = {sess, 16'(b)};
    return {56'h0, len, sess, last, {16{w}}};
  endfunction

  task automatic send_pkt(input logic [15:0] sess, input logic [15:0] len,
                          input int nbeats, input bit fwd);
    for (int b = 0; b < nbeats; b++) begin
      logic [600:0] beat;
      bit got;
      int w;
      beat = mk_beat(sess, len, b, b == nbeats - 1);
      if (fwd) exp_data.push_back(beat[512:0]);
      pkt_if.tdata  = beat;
      pkt_if.tvalid = 1'b1;
      got = 0;
      w   = 0;
      while (!got && w < 3000) begin
        @(negedge clk);
        got = pkt_if.tready;
        tick();
        w++;
      end
      if (!got) chk("pkt_beat_timeout", 0, 1);
    end
    pkt_if.tvalid = 1'b0;
    tick();
  endtask

  task automatic respond(input int dly, input logic [1:0] err, input logic [15:0] sess,
                         output int waited);
    bit got;
    int w;
    got = 0;
    w   = 0;
    while (!got && w < 3000) begin
      @(negedge clk);
      got = meta_if.tvalid && meta_if.tready;
      tick();
      w++;
    end
    if (!got) chk("meta_req_timeout", 0, 1);
    repeat (dly) tick();
    st_if.tdata  = {err, 30'h0, 16'h0000, sess};
    st_if.tvalid = 1'b1;
    got    = 0;
    waited = 0;
    while (!got && waited < 3000) begin
      @(negedge clk);
      got = st_if.tready;
      tick();
      waited++;
    end
    if (!got) chk("status_accept_timeout", 0, 1);
    st_if.tvalid = 1'b0;
  endtask

  // Snapshots of the event counters for per-test deltas.
  int s_meta, s_data, s_pkt;
  task automatic snap();
    s_meta = n_meta_hs;
    s_data = n_data_hs;
    s_pkt  = n_pkt_hs;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    bit done;
`ifdef ECHO_TX_CTRL_STATS_EN
    logic [31:0] s_ret, s_drp, s_snt;
`endif
    rst            = 1'b1;
    pkt_if.tdata   = '0;
    pkt_if.tvalid  = 1'b0;
    meta_if.tready = 1'b0;
    st_if.tdata    = '0;
    st_if.tvalid   = 1'b0;
    dat_if.tready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_meta_vld", meta_if.tvalid, 0);
    chk("rst_meta_dat", meta_if.tdata, 0);
    chk("rst_pkt_rdy", pkt_if.tready, 0);
    chk("rst_st_rdy", st_if.tready, 0);
    chk("rst_data_vld", dat_if.tvalid, 0);
`ifdef ECHO_TX_CTRL_STATS_EN
    chk("rst_stat_sent", stat_sent, 0);
    chk("rst_stat_retries", stat_retries, 0);
`endif
    tick();

    // 1: straight send, meta held under backpressure for a few cycles
    snap();
    exp_meta = 32'h0080_0005;
    fork
      send_pkt(16'h0005, 16'd128, 2, 1);
      respond(2, 2'd0, 16'h0005, wt);
      begin repeat (5) tick(); meta_if.tready = 1'b1; end
    join
    chk("t1_meta_value", last_meta_hs, 32'h0080_0005);
    chk("t1_meta_latency", meta_rise_cyc - pkt_rise_cyc, 1);
    chk("t1_meta_reqs", n_meta_hs - s_meta, 1);
    chk("t1_beats_out", n_data_hs - s_data, 2);

    // 2: two error refusals then success
    snap();
    exp_meta = {16'd128, 16'h0011};
    fork
      send_pkt(16'h0011, 16'd128, 2, 1);
      begin
        respond(2, 2'd1, 16'h0011, wt);
        respond(2, 2'd1, 16'h0011, wt);
        respond(2, 2'd0, 16'h0011, wt);
      end
    join
    chk("t2_meta_reqs", n_meta_hs - s_meta, 3);
    chk("t2_beats_out", n_data_hs - s_data, 2);

    // 3: four refusals exhaust the retries; packet drained
    snap();
`ifdef ECHO_TX_CTRL_STATS_EN
    s_ret = stat_retries; s_drp = stat_dropped;
`endif
    exp_meta = {16'd128, 16'h0022};
    fork
      send_pkt(16'h0022, 16'd128, 2, 0);
      begin
        for (int i = 0; i < 4; i++) respond(2, 2'd2, 16'h0022, wt);
      end
    join
    chk("t3_meta_reqs", n_meta_hs - s_meta, 4);
    chk("t3_beats_out", n_data_hs - s_data, 0);
    chk("t3_beats_drained", n_pkt_hs - s_pkt, 2);
`ifdef ECHO_TX_CTRL_STATS_EN
    chk("t3_stat_dropped", stat_dropped - s_drp, 1);
    chk("t3_stat_retries", stat_retries - s_ret, 3);
`endif

    // 4: timeout refusal; status raised during backoff waits for the next STATUS
    snap();
    exp_meta = {16'd64, 16'h0033};
    fork
      send_pkt(16'h0033, 16'd64, 1, 1);
      respond(1050, 2'd0, 16'h0033, wt);
    join
    chk("t4_status_held", longint'(wt > 1), 1);
    chk("t4_meta_reqs", n_meta_hs - s_meta, 2);
    chk("t4_beats_out", n_data_hs - s_data, 1);

    // 5: payload ready toggling 1010
    snap();
    exp_meta = {16'd192, 16'h0044};
    done = 0;
    fork
      begin send_pkt(16'h0044, 16'd192, 3, 1); done = 1; end
      respond(2, 2'd0, 16'h0044, wt);
      begin
        for (int i = 0; i < 3000 && !done; i++) begin
          dat_if.tready = (i % 2 == 0);
          tick();
        end
        dat_if.tready = 1'b1;
      end
    join
    chk("t5_beats_out", n_data_hs - s_data, 3);
    chk("t5_beats_taken", n_pkt_hs - s_pkt, 3);

    // 6: reset while beat 1 of 3 is presented to the stack
    exp_meta = {16'd192, 16'h0055};
    dat_if.tready = 1'b0;
    pkt_if.tdata  = mk_beat(16'h0055, 16'd192, 0, 0);
    pkt_if.tvalid = 1'b1;
    fork
      respond(2, 2'd0, 16'h0055, wt);
    join_none
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = dat_if.tvalid;
      tick();
    end
    chk("t6_reached_data", done, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pkt_if.tvalid = 1'b0;
    @(negedge clk);
    chk("t6_meta_vld", meta_if.tvalid, 0);
    chk("t6_meta_dat", meta_if.tdata, 0);
    chk("t6_pkt_rdy", pkt_if.tready, 0);
    chk("t6_st_rdy", st_if.tready, 0);
    chk("t6_data_vld", dat_if.tvalid, 0);
`ifdef ECHO_TX_CTRL_STATS_EN
    chk("t6_stat_sent", stat_sent, 0);
    chk("t6_stat_dropped", stat_dropped, 0);
`endif
    tick();
    dat_if.tready = 1'b1;
    repeat (2) tick();

    // 7: zero length goes straight to drain, no request
    snap();
    fork
      send_pkt(16'h0066, 16'd0, 1, 0);
    join
    chk("t7_meta_reqs", n_meta_hs - s_meta, 0);
    chk("t7_beats_drained", n_pkt_hs - s_pkt, 1);
    chk("t7_beats_out", n_data_hs - s_data, 0);

    // 8: status for another session is a refusal
    snap();
    exp_meta = {16'd64, 16'h0077};
    fork
      send_pkt(16'h0077, 16'd64, 1, 1);
      begin
        respond(2, 2'd0, 16'h0078, wt);
        respond(2, 2'd0, 16'h0077, wt);
      end
    join
    chk("t8_meta_reqs", n_meta_hs - s_meta, 2);
    chk("t8_beats_out", n_data_hs - s_data, 1);

    repeat (3) tick();
    chk("exp_data_left", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
